icache_refill_ctrl: RTL and testbench
=====================================

Name: icache_refill_ctrl

Overview:
- Lower-memory end of the L1 instruction-cache miss interface.
- Accepts the fetch stage's miss indication and miss address, then fetches the block-aligned line from memory as sequential narrow beats.
- Assembles the beats into one cache block and returns it with a single-cycle write strobe (wrEnable/wrAddr/instBlock) to the L1 I-cache.
- One outstanding miss at a time; memory returns beats in order.

Parameters:
- SIZE_PC, 32, PC/address width.
- CACHE_WIDTH, 256, cache block width in bits (32 bytes).
- MEM_DATA_W, 64, memory response beat width; CACHE_WIDTH must be an integer multiple of it.
- CNT_W, 16, width of the saturating refill counter.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- miss_i  in  1  L1I miss for the current fetch PC
- missAddr_i  in  SIZE_PC  miss address; any offset allowed
- memReqValid_o  out  1  memory read request valid
- memReqReady_i  in  1  memory accepts the request
- memReqAddr_o  out  SIZE_PC  block-aligned request address
- memRespValid_i  in  1  response beat valid
- memRespData_i  in  MEM_DATA_W  response beat data
- wrEnable_o  out  1  cache block write strobe, one cycle
- wrAddr_o  out  SIZE_PC  block-aligned write address
- instBlock_o  out  CACHE_WIDTH  assembled block
- busy_o  out  1  refill in progress; high in any state other than IDLE
- refillCount_o  out  CNT_W  completed refills, saturating

Behaviour:
- Constants: BEATS = CACHE_WIDTH/MEM_DATA_W (4). OFF = log2(CACHE_WIDTH/8) (5). The aligned address is the miss address with its low OFF bits cleared.
- Reset: state IDLE; all outputs 0, including instBlock_o, wrAddr_o, memReqAddr_o and refillCount_o; beat counter 0; lastAddr 0; lastValid 0.
- FSM states: IDLE, REQ, RESP, WRITE, HOLD.
- IDLE:
  - If miss_i=1, latch the aligned address into reqAddr and go to REQ.
  - Exception: if lastValid=1 and the aligned address equals lastAddr, ignore the miss. This suppresses stale duplicate misses.
  - lastValid clears on any cycle in IDLE with miss_i=0.
- REQ:
  - memReqValid_o=1 and memReqAddr_o=reqAddr, held stable until accepted.
  - On memReqValid_o & memReqReady_i, clear the beat counter and go to RESP.
  - miss_i and missAddr_i changes are ignored; the request is never retracted.
- RESP:
  - Each memRespValid_i=1 cycle writes memRespData_i into slice [cnt*MEM_DATA_W +: MEM_DATA_W] (beat 0 = LSBs), then cnt increments.
  - On the beat with cnt==BEATS-1, go to WRITE.
  - Gaps between beats are allowed and have no timeout.
- Responses outside RESP: memRespValid_i in IDLE, REQ, WRITE or HOLD is ignored and is a protocol violation (bench assertion).
- WRITE (exactly one cycle):
  - wrEnable_o=1, wrAddr_o=reqAddr, instBlock_o=assembled block.
  - refillCount_o increments, saturating at all-ones.
  - lastAddr<=reqAddr, lastValid<=1. Next state HOLD.
  - wrEnable_o is registered and is 0 in every other state.
  - instBlock_o/wrAddr_o hold their last values outside WRITE.
- HOLD (one cycle):
  - miss_i is ignored; the cache lookup settles on the freshly written line.
  - Next state IDLE.
- Latency: miss in IDLE at cycle T, with ready at T+1 and one beat per cycle from T+2 → wrEnable_o at T+6. Minimum gap between consecutive refills: 7 cycles.
- Reset mid-operation (any state):
  - Abandons the refill; no wrEnable_o; partial beats discarded.
  - Memory side must be reset concurrently; late beats after reset are ignored in IDLE.
- Simultaneous: memReqReady_i in the same cycle that REQ is entered counts. Response data in the same cycle as the REQ→RESP transition is ignored (responses follow acceptance by at least one cycle).

Decomposition:
- Shared package icache_refill_pkg: state enum (IDLE, REQ, RESP, WRITE, HOLD), BEATS, OFF, block-align function.
- One sub-module, refill_beat_buffer: CACHE_WIDTH register plus beat counter. Inputs: clear, beat valid, beat data. Outputs: block, last-beat flag.

Test Plan:
- Basic refill:
  - Stimulus: missAddr_i=0x00001234; ready immediately; beats 0x1111111111111111, 0x2222222222222222, 0x3333333333333333, 0x4444444444444444, one per cycle.
  - Response: memReqAddr_o=0x00001220; wrAddr_o=0x00001220; instBlock_o=0x4444…_3333…_2222…_1111…; wrEnable_o high exactly one cycle at T+6; refillCount_o=1.
- Backpressure: memReqReady_i low for 3 cycles → memReqValid_o held and memReqAddr_o stable all 4 cycles; one request only; wrEnable_o at T+9.
- Beat gaps: 2 idle cycles between each beat → data still packed in order; wrEnable_o one cycle after the 4th beat.
- Sticky miss: miss_i held high through HOLD and one cycle into IDLE with the same address 0x1220 → no second memReqValid_o. Miss to 0x2000 afterwards → new request with memReqAddr_o=0x00002000.
- Reset mid-RESP: reset asserted after beat 2 → wrEnable_o stays 0; busy_o=0 next cycle; refillCount_o=0; next miss starts a clean fill.
- Saturation: force refillCount_o to 0xFFFF (CNT_W=16) and complete a refill → count remains 0xFFFF.

Source files
------------

// File: rtl/icache_refill_pkg.sv
// Shared types and constants for the L1 I-cache refill path.
package icache_refill_pkg;
    localparam int PC_W    = 32;
    localparam int BLOCK_W = 256;
    localparam int BEAT_W  = 64;
    localparam int BEATS   = BLOCK_W / BEAT_W;
    localparam int OFF     = $clog2(BLOCK_W / 8);

    typedef enum logic [2:0] {IDLE, REQ, RESP, WRITE, HOLD} refillState_t;

    function automatic logic [PC_W-1:0] blockAlign(input logic [PC_W-1:0] addr);
        return {addr[PC_W-1:OFF], {OFF{1'b0}}};
    endfunction
endpackage

// File: rtl/icache_refill_ctrl_beat_buffer.sv
// Packs sequential memory beats into one cache block, beat 0 in the LSBs.
module refill_beat_buffer #(
    parameter int CACHE_WIDTH = 256,
    parameter int MEM_DATA_W  = 64
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   clear,
    input  logic                   beatValid,
    input  logic [MEM_DATA_W-1:0]  beatData,
    output logic [CACHE_WIDTH-1:0] block,
    output logic                   lastBeat
);
    localparam int BEATS = CACHE_WIDTH / MEM_DATA_W;
    localparam int CW    = (BEATS > 1) ? $clog2(BEATS) : 1;

    logic [CW-1:0]          cnt;
    logic [CACHE_WIDTH-1:0] blockReg;

    // block includes the beat arriving this cycle so the final beat can be
    // registered straight into the write port on the same edge.
    always_comb begin
        block = blockReg;
        if (beatValid)
            block[int'(cnt)*MEM_DATA_W +: MEM_DATA_W] = beatData;
    end

    assign lastBeat = beatValid && (cnt == CW'(BEATS - 1));

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            cnt      <= '0;
            blockReg <= '0;
        end else if (beatValid) begin
            blockReg <= block;
            cnt      <= cnt + CW'(1);
        end
    end
endmodule

// File: rtl/icache_refill_ctrl.sv
// L1 I-cache miss refill: one block-aligned read, beats assembled, one write strobe.
module icache_refill_ctrl
    import icache_refill_pkg::*;
#(
    parameter int SIZE_PC     = PC_W,
    parameter int CACHE_WIDTH = BLOCK_W,
    parameter int MEM_DATA_W  = BEAT_W,
    parameter int CNT_W       = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   miss_i,
    input  logic [SIZE_PC-1:0]     missAddr_i,
    output logic                   memReqValid_o,
    input  logic                   memReqReady_i,
    output logic [SIZE_PC-1:0]     memReqAddr_o,
    input  logic                   memRespValid_i,
    input  logic [MEM_DATA_W-1:0]  memRespData_i,
    output logic                   wrEnable_o,
    output logic [SIZE_PC-1:0]     wrAddr_o,
    output logic [CACHE_WIDTH-1:0] instBlock_o,
    output logic                   busy_o,
    output logic [CNT_W-1:0]       refillCount_o
);
    localparam int OFFL = $clog2(CACHE_WIDTH / 8);
    localparam logic [SIZE_PC-1:0] OFF_MASK = SIZE_PC'((64'd1 << OFFL) - 64'd1);

    refillState_t           state;
    logic [SIZE_PC-1:0]     reqAddr, lastAddr, alignedAddr;
    logic                   lastValid;
    logic [CNT_W-1:0]       refillCount;
    logic [CACHE_WIDTH-1:0] block;
    logic                   lastBeat, bufClear, beatValid;

    assign alignedAddr   = missAddr_i & ~OFF_MASK;
    assign memReqAddr_o  = reqAddr;
    assign refillCount_o = refillCount;
    assign bufClear      = (state == REQ) && memReqReady_i;
    // Beats coincident with acceptance are not yet legal and are dropped.
    assign beatValid     = (state == RESP) && memRespValid_i;

    refill_beat_buffer #(.CACHE_WIDTH(CACHE_WIDTH), .MEM_DATA_W(MEM_DATA_W)) uBuf (
        .clk(clk), .reset(reset), .clear(bufClear),
        .beatValid(beatValid), .beatData(memRespData_i),
        .block(block), .lastBeat(lastBeat)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            reqAddr       <= '0;
            lastAddr      <= '0;
            lastValid     <= 1'b0;
            memReqValid_o <= 1'b0;
            wrEnable_o    <= 1'b0;
            wrAddr_o      <= '0;
            instBlock_o   <= '0;
            busy_o        <= 1'b0;
            refillCount   <= '0;
        end else begin
            wrEnable_o <= 1'b0;
            case (state)
                IDLE: begin
                    if (!miss_i)
                        lastValid <= 1'b0;
                    // A miss still pointing at the line just written is stale.
                    else if (!(lastValid && alignedAddr == lastAddr)) begin
                        reqAddr       <= alignedAddr;
                        memReqValid_o <= 1'b1;
                        busy_o        <= 1'b1;
                        state         <= REQ;
                    end
                end
                REQ: if (memReqReady_i) begin
                    memReqValid_o <= 1'b0;
                    state         <= RESP;
                end
                RESP: if (lastBeat) begin
                    wrEnable_o  <= 1'b1;
                    wrAddr_o    <= reqAddr;
                    instBlock_o <= block;
                    if (refillCount != '1)
                        refillCount <= refillCount + 1'b1;
                    lastAddr    <= reqAddr;
                    lastValid   <= 1'b1;
                    state       <= WRITE;
                end
                WRITE: state <= HOLD;
                HOLD: begin
                    busy_o <= 1'b0;
                    state  <= IDLE;
                end
                default: begin
                    busy_o <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_icache_refill_ctrl.sv
// Directed bench for icache_refill_ctrl with hand-computed expectations.
module tb_icache_refill_ctrl;
    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         miss_i = 1'b0;
    logic [31:0]  missAddr_i = '0;
    logic         memReqValid_o;
    logic         memReqReady_i = 1'b0;
    logic [31:0]  memReqAddr_o;
    logic         memRespValid_i = 1'b0;
    logic [63:0]  memRespData_i = '0;
    logic         wrEnable_o;
    logic [31:0]  wrAddr_o;
    logic [255:0] instBlock_o;
    logic         busy_o;
    logic [15:0]  refillCount_o;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    icache_refill_ctrl dut (
        .clk(clk), .reset(reset), .miss_i(miss_i), .missAddr_i(missAddr_i),
        .memReqValid_o(memReqValid_o), .memReqReady_i(memReqReady_i),
        .memReqAddr_o(memReqAddr_o), .memRespValid_i(memRespValid_i),
        .memRespData_i(memRespData_i), .wrEnable_o(wrEnable_o), .wrAddr_o(wrAddr_o),
        .instBlock_o(instBlock_o), .busy_o(busy_o), .refillCount_o(refillCount_o)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    // Full refill: miss edge, rdyDly cycles of backpressure, gap idle cycles before each beat.
    task automatic refill(input logic [31:0] addr, input logic [31:0] expAddr, input int rdyDly,
                          input int gap, input logic [255:0] blk, input int expLat,
                          input logic [15:0] expCnt, input bit holdMiss);
        int t0;
        t0 = cyc;
        missAddr_i = addr;
        miss_i = 1'b1;
        step();
        if (!holdMiss) miss_i = 1'b0;
        chk("busy_req", busy_o, 1);
        for (int i = 0; i <= rdyDly; i++) begin
            chk("req_valid", memReqValid_o, 1);
            chk("req_addr", memReqAddr_o, expAddr);
            memReqReady_i = (i == rdyDly);
            if (i == rdyDly) begin
                memRespValid_i = 1'b1;
                memRespData_i  = 64'hDEAD_BEEF_DEAD_BEEF;
            end
            step();
        end
        memReqReady_i  = 1'b0;
        memRespValid_i = 1'b0;
        chk("req_drop", memReqValid_o, 0);
        for (int b = 0; b < 4; b++) begin
            for (int g = 0; g < gap; g++) begin
                memRespValid_i = 1'b0;
                step();
                chk("wr_early_gap", wrEnable_o, 0);
            end
            memRespValid_i = 1'b1;
            memRespData_i  = blk[b*64 +: 64];
            step();
            if (b < 3) chk("wr_early", wrEnable_o, 0);
        end
        memRespValid_i = 1'b0;
        chk("wr_en", wrEnable_o, 1);
        chk("latency", cyc - t0, expLat);
        chk("wr_addr", wrAddr_o, expAddr);
        chk("block", instBlock_o, blk);
        chk("count", refillCount_o, expCnt);
        chk("req_idle", memReqValid_o, 0);
        step();
        chk("wr_one_cycle", wrEnable_o, 0);
        chk("busy_hold", busy_o, 1);
        chk("block_hold", instBlock_o, blk);
        step();
        chk("busy_idle", busy_o, 0);
        chk("req_after", memReqValid_o, 0);
    endtask

    initial begin
        step();
        step();
        chk("rst_busy", busy_o, 0);
        chk("rst_wr", wrEnable_o, 0);
        chk("rst_req", memReqValid_o, 0);
        chk("rst_cnt", refillCount_o, 0);
        chk("rst_block", instBlock_o, 0);
        chk("rst_wraddr", wrAddr_o, 0);
        chk("rst_reqaddr", memReqAddr_o, 0);
        reset = 1'b0;

        // basic refill, miss held high so the stale-duplicate filter is exercised
        refill(32'h0000_1234, 32'h0000_1220, 0, 0,
               {64'h4444444444444444, 64'h3333333333333333,
                64'h2222222222222222, 64'h1111111111111111}, 6, 16'd1, 1'b1);
        step();
        chk("sticky_busy", busy_o, 0);
        chk("sticky_req", memReqValid_o, 0);
        miss_i = 1'b0;
        step();

        // backpressure, new line
        refill(32'h0000_2008, 32'h0000_2000, 3, 0,
               {64'hAAAA0003AAAA0003, 64'hAAAA0002AAAA0002,
                64'hAAAA0001AAAA0001, 64'hAAAA0000AAAA0000}, 9, 16'd2, 1'b0);

        // gaps between beats
        refill(32'h0000_3FFF, 32'h0000_3FE0, 0, 2,
               {64'h0123456789ABCDEF, 64'hFEDCBA9876543210,
                64'h5555AAAA5555AAAA, 64'h0F0F0F0F0F0F0F0F}, 14, 16'd3, 1'b0);

        // reset after three beats
        missAddr_i = 32'h0000_4010;
        miss_i = 1'b1;
        step();
        miss_i = 1'b0;
        memReqReady_i = 1'b1;
        step();
        memReqReady_i = 1'b0;
        for (int b = 0; b < 3; b++) begin
            memRespValid_i = 1'b1;
            memRespData_i  = 64'h9999_0000_0000_0000 | 64'(b);
            step();
        end
        memRespValid_i = 1'b0;
        reset = 1'b1;
        step();
        chk("mid_rst_busy", busy_o, 0);
        chk("mid_rst_wr", wrEnable_o, 0);
        chk("mid_rst_cnt", refillCount_o, 0);
        chk("mid_rst_block", instBlock_o, 0);
        reset = 1'b0;
        memRespValid_i = 1'b1;
        memRespData_i  = 64'h7777777777777777;
        step();
        memRespValid_i = 1'b0;
        chk("late_beat_busy", busy_o, 0);
        chk("late_beat_wr", wrEnable_o, 0);
        step();
        refill(32'h0000_4010, 32'h0000_4000, 0, 0,
               {64'hC000000000000003, 64'hC000000000000002,
                64'hC000000000000001, 64'hC000000000000000}, 6, 16'd1, 1'b0);

        // saturation
        force dut.refillCount = 16'hFFFF;
        #1;
        release dut.refillCount;
        refill(32'h0000_5000, 32'h0000_5000, 0, 0,
               {64'hE3E3E3E3E3E3E3E3, 64'hE2E2E2E2E2E2E2E2,
                64'hE1E1E1E1E1E1E1E1, 64'hE0E0E0E0E0E0E0E0}, 6, 16'hFFFF, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
